// File: rtl/tx_link_scheduler.sv
// Round-robin arbiter and stop-and-wait sequencer in front of a single link transmitter.
// Owns the frame sequence counter, retransmit timer and retry budget.
module tx_link_scheduler #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 16,
  parameter int unsigned SW        = 12,
  parameter int unsigned TO_CYC    = 64,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    fail,
  input  logic               tx_ready,
  output logic               tx_we,
  output logic [DW-1:0]      tx_din,
  output logic [SW-1:0]      tx_seq,
  output logic               tx_busy_n,
  output logic               tx_tim_out,
  input  logic [1:0]         ack_nak
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TO_CYC + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] AckCode = 2'b10;
  localparam logic [1:0] NakCode = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] fail_q, fail_d;
  logic            tx_we_q, tx_we_d;
  logic [DW-1:0]   tx_din_q, tx_din_d;
  logic [SW-1:0]   tx_seq_q, tx_seq_d;
  logic            tx_busy_n_q, tx_busy_n_d;
  logic            tx_tim_out_q, tx_tim_out_d;

  logic [DW-1:0]   req_word [NREQ];
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   cand;
  logic            is_ack;
  logic            is_nak;
  logic            timed_out;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*DW +: DW];
  end

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr_q) + k) % NREQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // 2'b11 decodes as neither ACK nor NAK, i.e. no response.
  assign is_ack    = (ack_nak == AckCode);
  assign is_nak    = (ack_nak == NakCode);
  assign timed_out = (timer_q == TW'(TO_CYC - 1));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    gnt_d        = '0;
    done_d       = '0;
    fail_d       = '0;
    tx_we_d      = 1'b0;
    tx_din_d     = tx_din_q;
    tx_seq_d     = tx_seq_q;
    tx_busy_n_d  = tx_busy_n_q;
    tx_tim_out_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel_found && tx_ready) begin
          gnt_d[sel_idx] = 1'b1;
          owner_d        = sel_idx;
          ptr_d          = PW'((32'(sel_idx) + 32'd1) % NREQ);
          tx_din_d       = req_word[sel_idx];
          tx_we_d        = 1'b1;
          tx_busy_n_d    = 1'b1;
          state_d        = StSend;
        end
      end

      StSend: begin
        timer_d = '0;
        state_d = StWait;
      end

      StWait: begin
        timer_d = timer_q + TW'(1);
        if (is_ack) begin
          done_d[owner_q] = 1'b1;
          tx_seq_d        = tx_seq_q + SW'(1);
          retry_d         = '0;
          tx_busy_n_d     = 1'b0;
          state_d         = StIdle;
        end else if (is_nak || timed_out) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            // Resend the latched frame unchanged; the transmitter only hears about timeouts.
            retry_d      = retry_q + RW'(1);
            tx_we_d      = 1'b1;
            tx_tim_out_d = !is_nak;
            state_d      = StSend;
          end else begin
            fail_d[owner_q] = 1'b1;
            tx_seq_d        = tx_seq_q + SW'(1);
            retry_d         = '0;
            tx_busy_n_d     = 1'b0;
            state_d         = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      owner_q      <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      fail_q       <= '0;
      tx_we_q      <= 1'b0;
      tx_din_q     <= '0;
      tx_seq_q     <= '0;
      tx_busy_n_q  <= 1'b0;
      tx_tim_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      tx_we_q      <= tx_we_d;
      tx_din_q     <= tx_din_d;
      tx_seq_q     <= tx_seq_d;
      tx_busy_n_q  <= tx_busy_n_d;
      tx_tim_out_q <= tx_tim_out_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign tx_we      = tx_we_q;
  assign tx_din     = tx_din_q;
  assign tx_seq     = tx_seq_q;
  assign tx_busy_n  = tx_busy_n_q;
  assign tx_tim_out = tx_tim_out_q;

endmodule
